// File: rtl/eth_rx_fcs_check.sv
// eth_rx_fcs_check: CRC-32 check, FCS strip, length check and PHY
// error merge on the MAC receive byte stream, with frame statistics.
module eth_rx_fcs_check #(
   parameter int MIN_LEN = 60,
   parameter int MAX_LEN = 1514,
   parameter int CNT_W   = 16
) (
   input  logic             clk_mac,
   input  logic             rst_n,
   input  logic             rx_vld,
   input  logic [7:0]       rx_dat,
   input  logic             rx_sof,
   input  logic             rx_eof,
   input  logic             rx_err,
   output logic             out_vld,
   output logic [7:0]       out_dat,
   output logic             out_sof,
   output logic             out_eof,
   output logic             out_err,
   output logic [CNT_W-1:0] stat_good,
   output logic [CNT_W-1:0] stat_crc_err,
   output logic [CNT_W-1:0] stat_len_err,
   output logic [CNT_W-1:0] stat_abort
);

   localparam logic [31:0] POLY    = 32'hEDB88320;
   localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
   // Byte count includes the 4 FCS bytes, so bounds are shifted by 4.
   localparam logic [16:0] LO_CNT  = 17'(MIN_LEN + 4);
   localparam logic [16:0] HI_CNT  = 17'(MAX_LEN + 4);

   typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

   state_t          state_q, state_d;
   logic [31:0]     crc_q, crc_d;
   logic [15:0]     cnt_q, cnt_d;
   logic            err_q, err_d;
   logic [3:0][7:0] dly_q;

   logic new_frm, cont, upd, full;
   logic crc_bad, len_bad;
   logic emit, emit_sof, emit_eof, emit_err;
   logic inc_good, inc_crc, inc_len, inc_abort;

   function automatic logic [31:0] crc_byte(
      input logic [31:0] c,
      input logic [7:0]  d
   );
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++)
         r = (r >> 1) ^ ((r[0] ^ d[i]) ? POLY : 32'h0);
      return r;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(
      input logic [CNT_W-1:0] v
   );
      return (&v) ? v : v + 1'b1;
   endfunction

   // Per-byte frame bookkeeping: CRC, byte count, sticky PHY error, checks.
   always_comb begin
      new_frm = rx_vld & rx_sof;
      cont    = rx_vld & ~rx_sof & (state_q != IDLE);
      upd     = new_frm | cont;
      crc_d   = crc_byte(new_frm ? 32'hFFFF_FFFF : crc_q, rx_dat);
      cnt_d   = new_frm ? 16'd1 :
                (&cnt_q) ? cnt_q : cnt_q + 16'd1;
      err_d   = rx_err | (err_q & ~new_frm);
      // Delay line already holds 4 bytes, so this byte pushes one out.
      full    = (state_q == STREAM) | (cnt_q == 16'd4);
      crc_bad = crc_d != RESIDUE;
      len_bad = ({1'b0, cnt_d} < LO_CNT) |
                ({1'b0, cnt_d} > HI_CNT);
   end

   // Next state, output strobes and statistic increments.
   always_comb begin
      state_d   = state_q;
      emit      = 1'b0;
      emit_sof  = 1'b0;
      emit_eof  = 1'b0;
      emit_err  = 1'b0;
      inc_good  = 1'b0;
      inc_crc   = 1'b0;
      inc_len   = 1'b0;
      inc_abort = 1'b0;
      unique case (1'b1)
         new_frm: begin
            // A sof mid-frame truncates the old one.
            if (state_q == STREAM) begin
               emit      = 1'b1;
               emit_eof  = 1'b1;
               emit_err  = 1'b1;
               inc_abort = 1'b1;
            end else if (state_q == FILL) begin
               inc_abort = 1'b1;
            end
            if (rx_eof) begin
               state_d   = IDLE;
               inc_abort = 1'b1;
            end else begin
               state_d   = FILL;
            end
         end
         cont: begin
            emit     = full;
            emit_sof = full & (state_q == FILL);
            if (rx_eof) begin
               state_d = IDLE;
               if (full) begin
                  emit_eof = 1'b1;
                  emit_err = crc_bad | len_bad | err_d;
                  inc_crc  = crc_bad;
                  inc_len  = ~crc_bad & len_bad;
                  inc_good = ~crc_bad & ~len_bad & ~err_d;
               end else begin
                  inc_abort = 1'b1;
               end
            end else if (full) begin
               state_d = STREAM;
            end
         end
         default: ;
      endcase
   end

   // State register.
   always_ff @(posedge clk_mac or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Frame registers and the 4-byte FCS delay line.
   always_ff @(posedge clk_mac or negedge rst_n) begin
      if (!rst_n) begin
         crc_q <= 32'hFFFF_FFFF;
         cnt_q <= '0;
         err_q <= 1'b0;
         dly_q <= '0;
      end else if (upd) begin
         crc_q <= crc_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
         dly_q <= {dly_q[2:0], rx_dat};
      end
   end

   // Registered output byte stream.
   always_ff @(posedge clk_mac or negedge rst_n) begin
      if (!rst_n) begin
         out_vld <= 1'b0;
         out_dat <= '0;
         out_sof <= 1'b0;
         out_eof <= 1'b0;
         out_err <= 1'b0;
      end else begin
         out_vld <= emit;
         out_sof <= emit_sof;
         out_eof <= emit_eof;
         out_err <= emit_err;
         if (emit) out_dat <= dly_q[3];
      end
   end

   // Saturating frame statistics.
   always_ff @(posedge clk_mac or negedge rst_n) begin
      if (!rst_n) begin
         stat_good    <= '0;
         stat_crc_err <= '0;
         stat_len_err <= '0;
         stat_abort   <= '0;
      end else begin
         if (inc_good)  stat_good    <= sat_inc(stat_good);
         if (inc_crc)   stat_crc_err <= sat_inc(stat_crc_err);
         if (inc_len)   stat_len_err <= sat_inc(stat_len_err);
         if (inc_abort) stat_abort   <= sat_inc(stat_abort);
      end
   end

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// tb_eth_rx_fcs_check: directed frames into two instances
// (MIN_LEN=0 and default) with byte, timing and counter checks.
module tb_eth_rx_fcs_check;

   typedef logic [7:0] bq_t[$];
   typedef struct {
      logic [7:0] d;
      logic       s;
      logic       e;
      logic       r;
      int         c;
   } ob_t;
   typedef ob_t obq_t[$];

   logic       clk_mac = 1'b0;
   logic       rst_n   = 1'b0;
   logic       rx_vld  = 1'b0;
   logic [7:0] rx_dat  = 8'h00;
   logic       rx_sof  = 1'b0;
   logic       rx_eof  = 1'b0;
   logic       rx_err  = 1'b0;

   logic        a_vld, a_sof, a_eof, a_err;
   logic [7:0]  a_dat;
   logic [15:0] a_good, a_crc, a_len, a_abort;
   logic        b_vld, b_sof, b_eof, b_err;
   logic [7:0]  b_dat;
   logic [15:0] b_good, b_crc, b_len, b_abort;

   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   in_cyc[$];
   obq_t ma, mb;

   eth_rx_fcs_check #(.MIN_LEN(0)) u_dut_a (
      .clk_mac(clk_mac), .rst_n(rst_n),
      .rx_vld(rx_vld), .rx_dat(rx_dat), .rx_sof(rx_sof),
      .rx_eof(rx_eof), .rx_err(rx_err),
      .out_vld(a_vld), .out_dat(a_dat), .out_sof(a_sof),
      .out_eof(a_eof), .out_err(a_err),
      .stat_good(a_good), .stat_crc_err(a_crc),
      .stat_len_err(a_len), .stat_abort(a_abort)
   );

   eth_rx_fcs_check u_dut_b (
      .clk_mac(clk_mac), .rst_n(rst_n),
      .rx_vld(rx_vld), .rx_dat(rx_dat), .rx_sof(rx_sof),
      .rx_eof(rx_eof), .rx_err(rx_err),
      .out_vld(b_vld), .out_dat(b_dat), .out_sof(b_sof),
      .out_eof(b_eof), .out_err(b_err),
      .stat_good(b_good), .stat_crc_err(b_crc),
      .stat_len_err(b_len), .stat_abort(b_abort)
   );

   always #5 clk_mac = ~clk_mac;

   always @(posedge clk_mac) cyc <= cyc + 1;

   // Capture output bytes with the index of the edge that produced them.
   always @(negedge clk_mac) begin
      if (rst_n) begin
         if (a_vld) ma.push_back('{a_dat, a_sof, a_eof, a_err, cyc - 1});
         if (b_vld) mb.push_back('{b_dat, b_sof, b_eof, b_err, cyc - 1});
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bq_t payload(input int n, input int seed);
      bq_t r;
      for (int i = 0; i < n; i++) r.push_back(8'(i * 7 + seed));
      return r;
   endfunction

   // Standard Ethernet FCS: inverted reflected CRC-32, sent LSB first.
   function automatic bq_t add_fcs(input bq_t p);
      bq_t         r;
      logic [31:0] c;
      r = p;
      c = 32'hFFFF_FFFF;
      foreach (p[i])
         for (int b = 0; b < 8; b++)
            c = (c >> 1) ^ ((c[0] ^ p[i][b]) ? 32'hEDB8_8320 : 32'h0);
      c = ~c;
      r.push_back(c[7:0]);
      r.push_back(c[15:8]);
      r.push_back(c[23:16]);
      r.push_back(c[31:24]);
      return r;
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk_mac);
         rx_vld = 1'b0;
         rx_sof = 1'b0;
         rx_eof = 1'b0;
         rx_err = 1'b0;
      end
   endtask

   task automatic send(input bq_t f, input int err_at,
                       input bit gaps, input bit eof_on);
      in_cyc.delete();
      foreach (f[i]) begin
         @(negedge clk_mac);
         rx_vld = 1'b1;
         rx_dat = f[i];
         rx_sof = (i == 0);
         rx_eof = eof_on && (i == f.size() - 1);
         rx_err = (i == err_at);
         in_cyc.push_back(cyc);
         if (gaps && i != f.size() - 1) idle($urandom_range(0, 2));
      end
   endtask

   task automatic chk_frame(input string tag, input obq_t got,
                            input bq_t exp, input logic exp_err,
                            input bit chk_cyc);
      chk({tag, " len"}, 32'(got.size()), 32'(exp.size()));
      if (got.size() == exp.size()) begin
         foreach (got[k]) begin
            chk({tag, " dat"}, 32'(got[k].d), 32'(exp[k]));
            chk({tag, " sof"}, 32'(got[k].s), 32'(k == 0));
            chk({tag, " eof"}, 32'(got[k].e), 32'(k == exp.size() - 1));
            if (k == exp.size() - 1)
               chk({tag, " err"}, 32'(got[k].r), 32'(exp_err));
            if (chk_cyc && k + 4 < in_cyc.size())
               chk({tag, " cyc"}, 32'(got[k].c), 32'(in_cyc[k + 4]));
         end
      end
   endtask

   logic [7:0] v1 [13] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
                           8'h37, 8'h38, 8'h39, 8'h26, 8'h39, 8'hF4,
                           8'hCB};

   initial begin
      bq_t  f1, f2, g, s, fa, fb, t3, fr;
      obq_t pa, pb;

      foreach (v1[i]) f1.push_back(v1[i]);
      idle(3);
      rst_n = 1'b1;
      idle(2);
      chk("rst a_vld", 32'(a_vld), 0);
      chk("rst b_vld", 32'(b_vld), 0);
      chk("rst b_good", 32'(b_good), 0);
      chk("rst b_abort", 32'(b_abort), 0);
      chk("rst a_good", 32'(a_good), 0);

      // Check-value frame "123456789".
      ma.delete(); mb.delete();
      send(f1, -1, 0, 1);
      idle(3);
      chk_frame("cv a", ma, f1[0:8], 1'b0, 1);
      chk_frame("cv b", mb, f1[0:8], 1'b1, 1);
      chk("cv a_good", 32'(a_good), 1);
      chk("cv b_len", 32'(b_len), 1);
      chk("cv b_good", 32'(b_good), 0);

      // Same frame with a corrupted data byte.
      f2 = f1;
      f2[4] = 8'h36;
      ma.delete(); mb.delete();
      send(f2, -1, 0, 1);
      idle(3);
      chk_frame("bad a", ma, f2[0:8], 1'b1, 1);
      chk_frame("bad b", mb, f2[0:8], 1'b1, 1);
      chk("bad a_crc", 32'(a_crc), 1);
      chk("bad b_crc", 32'(b_crc), 1);
      chk("bad b_len", 32'(b_len), 1);

      // Minimum-length good frame with random input gaps.
      g = add_fcs(payload(60, 3));
      mb.delete();
      send(g, -1, 1, 1);
      idle(3);
      chk_frame("good64", mb, g[0:59], 1'b0, 1);
      chk("good64 b_good", 32'(b_good), 1);

      // One byte short of minimum.
      s = add_fcs(payload(59, 5));
      mb.delete();
      send(s, -1, 1, 1);
      idle(3);
      chk_frame("short", mb, s[0:58], 1'b1, 1);
      chk("short b_len", 32'(b_len), 2);

      // PHY error on byte 20 of a good frame.
      mb.delete();
      send(g, 19, 0, 1);
      idle(3);
      chk_frame("phyerr", mb, g[0:59], 1'b1, 1);
      chk("phyerr b_good", 32'(b_good), 1);
      chk("phyerr b_crc", 32'(b_crc), 1);
      chk("phyerr b_len", 32'(b_len), 2);
      chk("phyerr b_abort", 32'(b_abort), 0);

      // Frame A cut by frame B's sof after 29 bytes.
      fa = add_fcs(payload(60, 9));
      fb = add_fcs(payload(60, 11));
      mb.delete();
      send(fa[0:28], -1, 0, 0);
      send(fb, -1, 0, 1);
      idle(3);
      chk("abort n", 32'(mb.size()), 86);
      if (mb.size() == 86) begin
         pa = mb[0:25];
         pb = mb[26:$];
         chk_frame("abort a", pa, fa[0:25], 1'b1, 0);
         chk("abort a eof cyc", 32'(pa[25].c), 32'(in_cyc[0]));
         chk_frame("abort b", pb, fb[0:59], 1'b0, 1);
      end
      chk("abort b_abort", 32'(b_abort), 1);
      chk("abort b_good", 32'(b_good), 2);

      // Three-byte frame never fills the delay line.
      t3.push_back(8'h01);
      t3.push_back(8'h02);
      t3.push_back(8'h03);
      mb.delete();
      send(t3, -1, 0, 1);
      idle(3);
      chk("tiny out", 32'(mb.size()), 0);
      chk("tiny b_abort", 32'(b_abort), 2);

      // Reset while streaming, then a clean frame.
      fr = add_fcs(payload(60, 13));
      send(fr[0:19], -1, 0, 0);
      @(posedge clk_mac);
      #1;
      chk("pre rst vld", 32'(b_vld), 1);
      rst_n  = 1'b0;
      rx_vld = 1'b0;
      rx_sof = 1'b0;
      #1;
      chk("mid rst vld", 32'(b_vld), 0);
      chk("mid rst good", 32'(b_good), 0);
      chk("mid rst abort", 32'(b_abort), 0);
      idle(2);
      rst_n = 1'b1;
      idle(2);
      mb.delete();
      send(fr, -1, 1, 1);
      idle(3);
      chk_frame("post rst", mb, fr[0:59], 1'b0, 1);
      chk("post rst good", 32'(b_good), 1);
      chk("post rst abort", 32'(b_abort), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
